// File: rtl/lfsr_req_arbiter.sv
// Shares a 4-bit maximal-length LFSR (x^4+x^3+1) between two requesters with a
// round-robin grant. The generator is seeded, warmed up, then serves one value per grant.
//
// Handshake: a requester raises req[i] and holds it until it sees gnt[i].
// gnt[i] is a one-cycle registered pulse, and rnd/rnd_valid qualify it in the same cycle.
// A req bit still high in its grant cycle counts as a fresh request.
module lfsr_req_arbiter #(
  parameter logic [3:0]  SEED   = 4'b1001,
  parameter int unsigned WARMUP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seed_load,
  input  logic [3:0] seed_val,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [3:0] rnd,
  output logic       rnd_valid,
  output logic       busy
);

  typedef enum logic {
    WARM  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [3:0] WARMUP_CNT = 4'(WARMUP);

  state_t     state, state_nxt;
  logic [3:0] lfsr, lfsr_nxt;
  logic [3:0] warm_cnt, warm_cnt_nxt;
  logic       rr_ptr, rr_ptr_nxt;      // 0: req[0] wins a tie, 1: req[1] wins a tie
  logic [1:0] gnt_nxt;
  logic [3:0] rnd_nxt;
  logic       rnd_valid_nxt;
  logic [1:0] winner;

  function automatic logic [3:0] lfsr_step(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  always_comb begin
    winner = 2'b00;
    if (req == 2'b11) begin
      winner = rr_ptr ? 2'b10 : 2'b01;
    end else begin
      winner = req;
    end
  end

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    warm_cnt_nxt  = warm_cnt;
    rr_ptr_nxt    = rr_ptr;
    gnt_nxt       = 2'b00;
    rnd_nxt       = rnd;
    rnd_valid_nxt = 1'b0;

    if (seed_load) begin
      // A zero seed would lock the LFSR, so substitute the reset seed instead.
      lfsr_nxt     = (seed_val == 4'b0000) ? SEED : seed_val;
      state_nxt    = WARM;
      warm_cnt_nxt = 4'd0;
    end else begin
      case (state)
        WARM: begin
          if (warm_cnt == WARMUP_CNT) begin
            // Only reachable with WARMUP=0: leave without taking a step.
            state_nxt = SERVE;
          end else begin
            lfsr_nxt     = lfsr_step(lfsr);
            warm_cnt_nxt = warm_cnt + 4'd1;
            if (warm_cnt + 4'd1 == WARMUP_CNT) begin
              state_nxt = SERVE;
            end
          end
        end
        SERVE: begin
          if (req != 2'b00) begin
            gnt_nxt       = winner;
            rnd_nxt       = lfsr;
            rnd_valid_nxt = 1'b1;
            lfsr_nxt      = lfsr_step(lfsr);
            rr_ptr_nxt    = winner[0];
          end
        end
        default: state_nxt = WARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= WARM;
      lfsr      <= SEED;
      warm_cnt  <= 4'd0;
      rr_ptr    <= 1'b0;
      gnt       <= 2'b00;
      rnd       <= 4'b0000;
      rnd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      warm_cnt  <= warm_cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      gnt       <= gnt_nxt;
      rnd       <= rnd_nxt;
      rnd_valid <= rnd_valid_nxt;
    end
  end

  assign busy = (state == WARM);

endmodule

// File: doc/lfsr_req_arbiter.md
Name: lfsr_req_arbiter

Overview:
- Owns a 4-bit maximal-length LFSR and shares its output between two requesters with a round-robin request/grant scheme.
- Sequences the generator: seed load, warm-up stepping, then serve mode.
- In serve mode, one LFSR value is consumed per grant, so the delivered sequence is deterministic regardless of request timing.
- Sits between the pseudo-random datapath and its consumer blocks.

Parameters:
- SEED, 4'b1001, LFSR value loaded at reset. Also used in place of a zero seed_val.
- WARMUP, 4, number of LFSR steps after reset or seed load before requests are served. Legal range 0..15.

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- reset, input, 1, synchronous, active-low.
- seed_load, input, 1, one-cycle strobe: load seed_val and restart warm-up.
- seed_val, input, 4, seed value, sampled when seed_load=1.
- req, input, 2, request per requester. A requester holds its bit high until granted.
- gnt, output, 2, one-hot grant, high for exactly one cycle, registered.
- rnd, output, 4, LFSR value delivered with the grant. Holds its last value otherwise.
- rnd_valid, output, 1, high in the same cycle as any gnt bit.
- busy, output, 1, high while in WARM; requests are not served while busy=1.

Behaviour:
- LFSR step: next = {q[2:0], q[3]^q[2]} (x^4+x^3+1), period 15.
  - Example sequence from 1001: 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, ...
  - Value 0000 is never reachable, because a zero seed is replaced by SEED.
- Reset (reset=0 at a rising edge) forces: lfsr=SEED, state=WARM, warm counter=0, rr pointer=0 (req[0] has priority), gnt=00, rnd=0000, rnd_valid=0, busy=1.
  - Reset mid-operation gives the same result and cancels any grant pending for the next cycle.
- States:
  - WARM: the LFSR steps on every edge and the counter increments; gnt=00, rnd_valid=0, busy=1.
    - After exactly WARMUP steps the block moves to SERVE, and busy=0 from then on.
    - If WARMUP=0, the first edge after reset release moves to SERVE with no step taken.
  - SERVE: on an edge with req!=00, the block registers:
    - gnt = one-hot winner;
    - rnd = current lfsr;
    - rnd_valid = 1;
    - lfsr steps once;
    - rr pointer moves to the non-winner.
  - SERVE with req=00: gnt=00, rnd_valid=0, lfsr and pointer hold.
- Arbitration:
  - A single requester always wins.
  - When both request, the winner is the one the pointer designates.
  - With both held continuously, grants alternate every cycle: 01, 10, 01, ...
- Latency: a request sampled at edge N produces gnt and rnd valid during the cycle after edge N. Maximum throughput is one grant per cycle.
  - A request still high in the cycle its gnt is asserted counts as a new request.
- seed_load=1 (with reset=1), in any state:
  - lfsr = (seed_val==0) ? SEED : seed_val;
  - state = WARM, counter = 0, gnt=00, rnd_valid=0, busy=1;
  - rr pointer and rnd hold.
  - seed_load wins over a simultaneous req. That request is not granted and must be held by its owner.
- Warm counter width is 4 bits. WARMUP=15 still terminates correctly.

Test Plan:
1. Reset, WARMUP=4, req=01 held from reset release -> busy=1 and gnt=00 for 4 cycles. Then gnt=01 with rnd=1010, followed by rnd=0101, 1011 on successive cycles.
2. Both requesting (req=11 held) in SERVE after reset warm-up -> gnt sequence 01, 10, 01, 10 with rnd 1010, 0101, 1011, 0111; rnd_valid=1 every cycle.
3. seed_load=1, seed_val=0001, with req=11 in the same cycle -> next cycle gnt=00, busy=1 for 4 cycles (LFSR walks 0001, 0010, 0100, 1001, 0011). First grant goes to the pointer-designated requester with rnd=0011.
4. seed_load with seed_val=0000 -> behaves as reset seed: first grant after warm-up gives rnd=1010.
5. req=01 held for 16 consecutive grants -> rnd repeats with period 15: grant 16 equals grant 1 (1010), and 0000 never appears.
6. reset=0 asserted during a stream of grants -> next cycle gnt=00, rnd=0000, rnd_valid=0, busy=1. The sequence restarts exactly as in scenario 1.
